// File: rtl/mem_bus_arbiter_pkg.sv
// Shared memory-bus types: command encoding, tag/address widths, requester and arbiter state enums.
package sys_defs;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [31:0] ADDR;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } REQ_OWNER;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } ARB_STATE;

endpackage

// File: rtl/mem_bus_arbiter_owner_table.sv
// Per-tag owner record: set on accepted loads, cleared on data return, combinational lookup.
// Clear and set land on the same edge; set wins, so a tag reissued in its return cycle keeps its new owner.
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [3:0] set_tag,
  input  logic       set_owner,
  input  logic       clr_en,
  input  logic [3:0] clr_tag,
  input  logic [3:0] lookup_tag,
  output logic       lookup_vld,
  output logic       lookup_owner
);

  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] owner;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      owner <= '0;
    end else begin
      if (clr_en) valid[clr_tag] <= 1'b0;
      if (set_en && (set_tag != 4'd0)) begin
        valid[set_tag] <= 1'b1;
        owner[set_tag] <= set_owner;
      end
    end
  end

  assign lookup_vld   = valid[lookup_tag];
  assign lookup_owner = owner[lookup_tag];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates icache/dcache onto one memory port, holding a grant until memory returns a nonzero tag.
// Request path and data-tag steering are combinational; tag ownership and tag_error update on the edge.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS   = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  icache_command,
  input  logic [31:0] icache_addr,
  input  logic [1:0]  dcache_command,
  input  logic [31:0] dcache_addr,
  input  logic [63:0] dcache_store_data,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [3:0]  mem2proc_data_tag,
  input  logic [63:0] mem2proc_data,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic [3:0]  icache_transaction_tag,
  output logic [3:0]  dcache_transaction_tag,
  output logic [3:0]  icache_data_tag,
  output logic [3:0]  dcache_data_tag,
  output logic [63:0] resp_data,
  output logic        tag_error
);

  localparam int SCW = $clog2(STARVE_MAX + 1);

  ARB_STATE       state;
  logic [SCW-1:0] starve_cnt;
  logic           i_req, d_req, grant_i, grant_d, accepted;
  logic           data_ret, lookup_vld, lookup_owner;

  assign i_req = (icache_command != MEM_NONE);
  assign d_req = (dcache_command != MEM_NONE);

  // A holder that withdraws releases the bus for the cycle; arbitration resumes from IDLE next cycle.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_req && d_req) begin
          if (starve_cnt == SCW'(STARVE_MAX)) grant_i = 1'b1;
          else                                grant_d = 1'b1;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
      end
      ARB_HOLD_I: grant_i = i_req;
      ARB_HOLD_D: grant_d = d_req;
      default: ;
    endcase
  end

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_i) begin
      proc2mem_command = icache_command;
      proc2mem_addr    = icache_addr;
    end else if (grant_d) begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = dcache_store_data;
    end
  end

  assign accepted               = (grant_i || grant_d) && (mem2proc_transaction_tag != 4'd0);
  assign icache_transaction_tag = grant_i ? mem2proc_transaction_tag : 4'd0;
  assign dcache_transaction_tag = grant_d ? mem2proc_transaction_tag : 4'd0;

  assign data_ret        = (mem2proc_data_tag != 4'd0);
  assign icache_data_tag = (data_ret && lookup_vld && lookup_owner == OWN_ICACHE) ? mem2proc_data_tag : 4'd0;
  assign dcache_data_tag = (data_ret && lookup_vld && lookup_owner == OWN_DCACHE) ? mem2proc_data_tag : 4'd0;
  assign resp_data       = mem2proc_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      tag_error  <= 1'b0;
    end else begin
      if (!(grant_i || grant_d) || accepted) state <= ARB_IDLE;
      else if (grant_i)                      state <= ARB_HOLD_I;
      else                                   state <= ARB_HOLD_D;

      if (grant_i && accepted)
        starve_cnt <= '0;
      else if (i_req && !grant_i && (starve_cnt != SCW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SCW'(1);

      if (data_ret && !lookup_vld) tag_error <= 1'b1;
    end
  end

  mem_tag_owner_table #(
    .NUM_TAGS(NUM_TAGS)
  ) u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .set_en      (accepted && (proc2mem_command == MEM_LOAD)),
    .set_tag     (mem2proc_transaction_tag),
    .set_owner   (grant_d ? OWN_DCACHE : OWN_ICACHE),
    .clr_en      (data_ret),
    .clr_tag     (mem2proc_data_tag),
    .lookup_tag  (mem2proc_data_tag),
    .lookup_vld  (lookup_vld),
    .lookup_owner(lookup_owner)
  );

endmodule
